// File: rtl/booth_pkg.sv
// Shared widths, FSM encoding and index helpers for the radix-4 Booth
// partial-product accumulator.
package booth_pkg;

  localparam int N      = 16;
  localparam int NUM_PP = N / 2;
  localparam int PPW    = N + 2;
  localparam int PW     = 2 * N;
  localparam int IDXW   = $clog2(NUM_PP);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_PP - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/booth_pp_align.sv
// Sign-extends one Booth partial product to 2N bits and shifts it to its
// radix-4 weight. Define BOOTH_ACC_NEG_CORR_EN to fold in the deferred +1.
module booth_pp_align
  import booth_pkg::*;
(
  input  logic [PPW-1:0]  pp_i,
  input  logic [IDXW-1:0] idx_i,
  input  logic            neg_i,
  output logic [PW-1:0]   addend_o
);

  logic [PW-1:0] pp_ext;
  logic [IDXW:0] shamt;

  assign pp_ext = {{(PW - PPW){pp_i[PPW-1]}}, pp_i};
  assign shamt  = {idx_i, 1'b0};

`ifdef BOOTH_ACC_NEG_CORR_EN
  // One's-complement digit plus its +1 at the same weight gives the true negation.
  logic [PW-1:0] corr;
  assign corr     = PW'(neg_i) << shamt;
  assign addend_o = (pp_ext << shamt) + corr;
`else
  logic unused_neg;
  assign unused_neg = neg_i;
  assign addend_o   = pp_ext << shamt;
`endif

endmodule

// File: rtl/booth_pp_accumulator.sv
// Running-sum accumulator for radix-4 Booth partial products with a
// valid/ready product output. Optional feature macro: BOOTH_ACC_NEG_CORR_EN.
module booth_pp_accumulator
  import booth_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           pp_valid,
  output logic           pp_ready,
  input  logic [PPW-1:0] pp_data,
  input  logic           pp_neg,
  output logic           prod_valid,
  input  logic           prod_ready,
  output logic [PW-1:0]  prod
);

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            prod_valid_q, prod_valid_d;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   sum;

  booth_pp_align u_align (
    .pp_i     (pp_data),
    .idx_i    (idx_q),
    .neg_i    (pp_neg),
    .addend_o (addend)
  );

  // acc_q is zero whenever the FSM sits in IDLE, so one adder serves both states.
  assign sum = acc_q + addend;

  assign pp_ready   = (state_q != DONE) && !reset;
  assign prod_valid = prod_valid_q;
  assign prod       = prod_q;

  always_comb begin
    // NOTE: every target gets a default before the branches so no path leaves it unassigned and infers a latch.
    state_d      = state_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    prod_d       = prod_q;
    prod_valid_d = prod_valid_q;

    if (flush) begin
      state_d      = IDLE;
      acc_d        = '0;
      idx_d        = '0;
      prod_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pp_valid) begin
            acc_d   = sum;
            idx_d   = IDXW'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (pp_valid) begin
            acc_d = sum;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d      = DONE;
              prod_d       = sum;
              prod_valid_d = 1'b1;
            end
          end
        end
        DONE: begin
          if (prod_ready) begin
            state_d      = IDLE;
            acc_d        = '0;
            idx_d        = '0;
            prod_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      idx_q        <= '0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator; expected products are hand-derived
// from the multiplicand/multiplier pairs and Booth digit sequences.
module tb_booth_pp_accumulator;
  import booth_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic           pp_valid;
  logic           pp_ready;
  logic [PPW-1:0] pp_data;
  logic           pp_neg;
  logic           prod_valid;
  logic           prod_ready;
  logic [PW-1:0]  prod;

  int n_cmp = 0;
  int n_err = 0;

  typedef logic [PPW-1:0] pp_vec_t [NUM_PP];
  typedef logic           neg_vec_t [NUM_PP];

  pp_vec_t  v_3x5, v_7xm1, v_min, v_ones;
  neg_vec_t n_zero, n_7xm1;

  booth_pp_accumulator dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .pp_valid   (pp_valid),
    .pp_ready   (pp_ready),
    .pp_data    (pp_data),
    .pp_neg     (pp_neg),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod       (prod)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input pp_vec_t pps, input neg_vec_t negs, input string tag);
    for (int k = 0; k < NUM_PP; k++) begin
      pp_valid = 1'b1;
      pp_data  = pps[k];
      pp_neg   = negs[k];
      step();
      if (k == NUM_PP - 2) check({tag, " valid_before_last"}, 64'(prod_valid), 64'd0);
    end
    pp_valid = 1'b0;
    pp_neg   = 1'b0;
  endtask

  task automatic finish_prod(input logic [PW-1:0] exp, input string tag);
    check({tag, " prod_valid"}, 64'(prod_valid), 64'd1);
    check({tag, " prod"},       64'(prod),       64'(exp));
    check({tag, " pp_ready_done"}, 64'(pp_ready), 64'd0);
    prod_ready = 1'b1;
    step();
    prod_ready = 1'b0;
    check({tag, " valid_cleared"}, 64'(prod_valid), 64'd0);
    check({tag, " pp_ready_idle"}, 64'(pp_ready),   64'd1);
  endtask

  initial begin
    v_3x5  = '{18'd3, 18'd3, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0};
    v_min  = '{18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'h10000};
    v_ones = '{18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF,
               18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF};
    n_zero = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef BOOTH_ACC_NEG_CORR_EN
    v_7xm1 = '{18'h3FFF8, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0};
    n_7xm1 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    v_7xm1 = '{18'h3FFF9, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0};
    n_7xm1 = n_zero;
`endif

    reset      = 1'b1;
    flush      = 1'b0;
    pp_valid   = 1'b0;
    pp_data    = '0;
    pp_neg     = 1'b0;
    prod_ready = 1'b0;
    step();
    step();
    check("reset pp_ready",   64'(pp_ready),   64'd0);
    check("reset prod_valid", 64'(prod_valid), 64'd0);
    check("reset prod",       64'(prod),       64'd0);
    reset = 1'b0;
    #1;
    check("post_reset pp_ready", 64'(pp_ready), 64'd1);

    // 3 x 5 = 15
    feed(v_3x5, n_zero, "3x5");
    finish_prod(32'h0000000F, "3x5");

    // 7 x -1 = -7
    feed(v_7xm1, n_7xm1, "7xm1");
    finish_prod(32'hFFFFFFF9, "7xm1");

    // -32768 x -32768 = 2^30
    feed(v_min, n_zero, "min");
    finish_prod(32'h40000000, "min");

    // -1 at every weight: -(4^8-1)/3 = -21845
    feed(v_ones, n_zero, "ones");
    finish_prod(32'hFFFFAAAB, "ones");

    // Back-pressure with pp_valid held high; the handshake cycle must not take a pp.
    feed(v_3x5, n_zero, "bp");
    pp_valid = 1'b1;
    pp_data  = 18'h3FFFF;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp pp_ready_held", 64'(pp_ready),   64'd0);
      check("bp prod_stable",   64'(prod),       64'h0000000F);
      check("bp valid_held",    64'(prod_valid), 64'd1);
    end
    prod_ready = 1'b1;
    step();
    prod_ready = 1'b0;
    pp_valid   = 1'b0;
    check("bp released_valid", 64'(prod_valid), 64'd0);
    check("bp released_ready", 64'(pp_ready),   64'd1);
    feed(v_7xm1, n_7xm1, "bp_next");
    finish_prod(32'hFFFFFFF9, "bp_next");

    // Three-cycle bubble between pp2 and pp3.
    for (int k = 0; k < NUM_PP; k++) begin
      if (k == 3) begin
        pp_valid = 1'b0;
        for (int g = 0; g < 3; g++) step();
        check("bubble stalled_valid", 64'(prod_valid), 64'd0);
      end
      pp_valid = 1'b1;
      pp_data  = v_3x5[k];
      step();
    end
    pp_valid = 1'b0;
    finish_prod(32'h0000000F, "bubble");

    // Reset after three accepts discards the partial sum.
    for (int k = 0; k < 3; k++) begin
      pp_valid = 1'b1;
      pp_data  = 18'h3FFFF;
      step();
    end
    pp_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("abort_reset pp_ready", 64'(pp_ready), 64'd1);
    feed(v_3x5, n_zero, "abort_reset");
    finish_prod(32'h0000000F, "abort_reset");

    // Flush coincident with the last pp wins over the accept.
    for (int k = 0; k < NUM_PP; k++) begin
      pp_valid = 1'b1;
      pp_data  = v_3x5[k];
      if (k == NUM_PP - 1) flush = 1'b1;
      step();
    end
    pp_valid = 1'b0;
    flush    = 1'b0;
    check("flush no_valid", 64'(prod_valid), 64'd0);
    check("flush pp_ready", 64'(pp_ready),   64'd1);
    check("flush prod_kept", 64'(prod),      64'h0000000F);
    feed(v_min, n_zero, "after_flush");
    finish_prod(32'h40000000, "after_flush");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
